// File: rtl/bcd_converter_pkg.sv
// Shared constants and helpers for the binary-to-BCD converter.
// Used by the converter top and its digit-adjust sub-module.
package bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam int unsigned BCD_MAX    = 9999;
    localparam logic [15:0] SAT_VALUE  = 16'h9999;

    // Units digit is always shown; a higher digit is shown once anything at or above it is nonzero.
    function automatic logic [3:0] lead_mask(input logic [15:0] digits);
        logic [3:0] m;
        m[0] = 1'b1;
        m[3] = (digits[15:12] != 4'd0);
        m[2] = m[3] | (digits[11:8] != 4'd0);
        m[1] = m[2] | (digits[7:4] != 4'd0);
        return m;
    endfunction

endpackage

// File: rtl/bcd_converter_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter with leading-zero blanking, feeding the
// 4-digit display. Results are registered and change only on the done edge.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; previous result held on the outputs
// ST_SHIFT  | one add-3/shift step per clock, WIDTH steps in total
// ST_FINISH | publish bcd/digit_mask/overflow and pulse done
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             blank_zeros,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic [3:0]       digit_mask,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [15:0]        scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blank_q, blank_d;
    logic               sat_q, sat_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [3:0]         mask_q, mask_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [15:0]        adj;
    logic [WIDTH+15:0]  shift_all;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .din  (scratch_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Scratch and operand shift as one register pair; the thousands carry-out
    // is dropped because values above 9999 are saturated from the captured compare.
    assign shift_all = {adj, operand_q} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            blank_q   <= 1'b0;
            sat_q     <= 1'b0;
            bcd_q     <= 16'h0000;
            mask_q    <= 4'b0001;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            blank_q   <= blank_d;
            sat_q     <= sat_d;
            bcd_q     <= bcd_d;
            mask_q    <= mask_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        blank_d   = blank_q;
        sat_d     = sat_q;
        bcd_d     = bcd_q;
        mask_d    = mask_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    operand_d = value;
                    blank_d   = blank_zeros;
                    sat_d     = (32'(value) > BCD_MAX);
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = shift_all[WIDTH +: 16];
                operand_d = shift_all[WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (sat_q) begin
                    bcd_d  = SAT_VALUE;
                    mask_d = 4'b1111;
                    ovf_d  = 1'b1;
                end else begin
                    bcd_d  = scratch_q;
                    mask_d = blank_q ? lead_mask(scratch_q) : 4'b1111;
                    ovf_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign bcd        = bcd_q;
    assign digit_mask = mask_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter: an 8-bit and a 14-bit instance share
// clock and reset; results are compared against a decimal-arithmetic model.
module tb_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, blank8 = 1'b0;
    logic [7:0]  value8 = '0;
    logic        busy8, done8, ovf8;
    logic [15:0] bcd8;
    logic [3:0]  mask8;

    logic        start14 = 1'b0, blank14 = 1'b0;
    logic [13:0] value14 = '0;
    logic        busy14, done14, ovf14;
    logic [15:0] bcd14;
    logic [3:0]  mask14;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_converter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .value(value8), .blank_zeros(blank8),
        .busy(busy8), .done(done8), .bcd(bcd8), .digit_mask(mask8), .overflow(ovf8)
    );

    bcd_converter #(.WIDTH(14)) u_dut14 (
        .clk(clk), .rst(rst), .start(start14), .value(value14), .blank_zeros(blank14),
        .busy(busy14), .done(done14), .bcd(bcd14), .digit_mask(mask14), .overflow(ovf14)
    );

    // Reference model: plain decimal arithmetic on the integer value.
    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] ref_mask(input int v, input bit b);
        if (v > 9999 || !b) return 4'b1111;
        if (v >= 1000) return 4'b1111;
        if (v >= 100)  return 4'b0111;
        if (v >= 10)   return 4'b0011;
        return 4'b0001;
    endfunction

    function automatic logic ref_ovf(input int v);
        return (v > 9999);
    endfunction

    // Stimulus only: pulse start, scramble inputs mid-conversion, wait for done.
    task automatic convert(input bit wide, input int v, input bit b,
                           output int lat, output int busy_n, output int changes, output bit timeout);
        logic [15:0] b0;
        logic [3:0]  m0;
        logic        o0;
        @(negedge clk);
        if (wide) begin value14 = 14'(v); blank14 = b; start14 = 1'b1; end
        else      begin value8  = 8'(v);  blank8  = b; start8  = 1'b1; end
        @(negedge clk);
        start8 = 1'b0;
        start14 = 1'b0;
        if (wide) begin value14 = 14'($urandom); blank14 = ~b; end
        else      begin value8  = 8'($urandom);  blank8  = ~b; end
        b0 = wide ? bcd14 : bcd8;
        m0 = wide ? mask14 : mask8;
        o0 = wide ? ovf14 : ovf8;
        busy_n = (wide ? busy14 : busy8) ? 1 : 0;
        lat = 0;
        changes = 0;
        timeout = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (wide ? done14 : done8) begin
                lat = i;
                timeout = 1'b0;
                break;
            end
            if (wide ? busy14 : busy8) busy_n++;
            if ((wide ? bcd14 : bcd8) !== b0 || (wide ? mask14 : mask8) !== m0 ||
                (wide ? ovf14 : ovf8) !== o0) changes++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bcd8 !== 16'h0000) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", bcd8); end
        checks++; if (mask8 !== 4'b0001) begin failures++; $display("FAIL reset_mask got=%b exp=0001", mask8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
        checks++; if (ovf8 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf8); end
        checks++; if ({bcd14, mask14, busy14, done14, ovf14} !== {16'h0000, 4'b0001, 3'b000})
            begin failures++; $display("FAIL reset_w14 got=%h/%b/%b%b%b", bcd14, mask14, busy14, done14, ovf14); end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        int lat, busy_n, changes;
        bit to;
        convert(1'b0, 255, 1'b1, lat, busy_n, changes, to);
        checks++; if (to) begin failures++; $display("FAIL lat255_timeout got=no_done exp=done"); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL lat255_latency got=%0d exp=9", lat); end
        checks++; if (busy_n !== 9) begin failures++; $display("FAIL lat255_busy got=%0d exp=9", busy_n); end
        checks++; if (changes !== 0) begin failures++; $display("FAIL lat255_stable got=%0d exp=0", changes); end
        checks++; if (bcd8 !== 16'h0255) begin failures++; $display("FAIL lat255_bcd got=%h exp=0255", bcd8); end
        checks++; if (mask8 !== 4'b0111) begin failures++; $display("FAIL lat255_mask got=%b exp=0111", mask8); end
        @(negedge clk);
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL lat255_done_width got=%b exp=0", done8); end
    endtask

    task automatic test_blanking;
        int vals[2] = '{0, 100};
        int lat, busy_n, changes;
        bit to;
        for (int b = 0; b < 2; b++) begin
            foreach (vals[k]) begin
                convert(1'b0, vals[k], b[0], lat, busy_n, changes, to);
                checks++; if (to || bcd8 !== ref_bcd(vals[k]))
                    begin failures++; $display("FAIL blank_bcd v=%0d b=%0d got=%h exp=%h", vals[k], b, bcd8, ref_bcd(vals[k])); end
                checks++; if (mask8 !== ref_mask(vals[k], b[0]))
                    begin failures++; $display("FAIL blank_mask v=%0d b=%0d got=%b exp=%b", vals[k], b, mask8, ref_mask(vals[k], b[0])); end
            end
        end
    endtask

    task automatic test_random;
        int lat, busy_n, changes, v;
        bit to, b;
        for (int n = 0; n < 24; n++) begin
            v = $urandom_range(0, 255);
            b = 1'($urandom);
            convert(1'b0, v, b, lat, busy_n, changes, to);
            checks++;
            if (to || lat != 9 || changes != 0 || bcd8 !== ref_bcd(v) || mask8 !== ref_mask(v, b) || ovf8 !== 1'b0) begin
                failures++;
                $display("FAIL rand8 v=%0d b=%0d got=%h/%b/%b lat=%0d chg=%0d exp=%h/%b/0 lat=9",
                         v, b, bcd8, mask8, ovf8, lat, changes, ref_bcd(v), ref_mask(v, b));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_q[3] = '{16'h0003, 16'h0042, 16'h0009};
        int gap;
        bit seen;
        @(negedge clk);
        blank8 = 1'b0;
        value8 = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        value8 = 8'd42;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            gap = 0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (done8) begin seen = 1'b1; gap = i + 1; break; end
            end
            checks++; if (!seen || bcd8 !== exp_q[k] || mask8 !== 4'b1111)
                begin failures++; $display("FAIL b2b_result k=%0d got=%h/%b exp=%h/1111", k, bcd8, mask8, exp_q[k]); end
            if (k > 0) begin
                checks++; if (gap !== 10) begin failures++; $display("FAIL b2b_gap k=%0d got=%0d exp=10", k, gap); end
            end
            @(negedge clk);
            if (k == 0) value8 = 8'd9;
            if (k == 1) begin start8 = 1'b0; value8 = 8'd200; end
        end
        gap = 0;
        repeat (14) begin @(negedge clk); if (done8) gap++; end
        checks++; if (gap !== 0) begin failures++; $display("FAIL b2b_extra_done got=%0d exp=0", gap); end
    endtask

    task automatic test_ignore_start;
        int seen;
        @(negedge clk);
        value8 = 8'd77; blank8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        value8 = 8'd200; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                seen++;
                if (seen == 1) begin
                    checks++; if (bcd8 !== 16'h0077 || mask8 !== 4'b0011)
                        begin failures++; $display("FAIL ignore_result got=%h/%b exp=0077/0011", bcd8, mask8); end
                end
            end
        end
        checks++; if (seen !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", seen); end
    endtask

    task automatic test_reset_mid;
        int lat, busy_n, changes, seen;
        bit to;
        convert(1'b0, 255, 1'b0, lat, busy_n, changes, to);
        checks++; if (to || bcd8 !== 16'h0255) begin failures++; $display("FAIL rmid_prior got=%h exp=0255", bcd8); end
        @(negedge clk);
        value8 = 8'd17; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({bcd8, mask8, busy8, done8, ovf8} !== {16'h0000, 4'b0001, 3'b000})
            begin failures++; $display("FAIL rmid_outputs got=%h/%b/%b%b%b exp=0000/0001/000", bcd8, mask8, busy8, done8, ovf8); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin @(negedge clk); if (done8) seen++; end
        checks++; if (seen !== 0 || bcd8 !== 16'h0000 || busy8 !== 1'b0)
            begin failures++; $display("FAIL rmid_after got=done%0d/%h/%b exp=done0/0000/0", seen, bcd8, busy8); end
    endtask

    task automatic test_width14;
        int vals[5] = '{9999, 12345, 8191, 10000, 16383};
        int lat, busy_n, changes, v;
        bit to, b;
        for (int n = 0; n < 17; n++) begin
            v = (n < 5) ? vals[n] : int'($urandom_range(0, 16383));
            b = (n < 5) ? 1'b1 : 1'($urandom);
            convert(1'b1, v, b, lat, busy_n, changes, to);
            checks++;
            if (to || lat != 15 || changes != 0 || bcd14 !== ref_bcd(v) || mask14 !== ref_mask(v, b) || ovf14 !== ref_ovf(v)) begin
                failures++;
                $display("FAIL w14 v=%0d b=%0d got=%h/%b/%b lat=%0d chg=%0d exp=%h/%b/%b lat=15",
                         v, b, bcd14, mask14, ovf14, lat, changes, ref_bcd(v), ref_mask(v, b), ref_ovf(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_blanking();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_width14();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
